// File: rtl/carfield_eoc_collector.sv
// End-of-computation collector: merges per-domain exit codes into one done/pass/fail verdict.
// Optional completion timeout is compiled in with `define CARFIELD_EOC_TIMEOUT_EN.
module carfield_eoc_collector #(
    parameter int unsigned NumCh        = 4,
    parameter int unsigned CodeWidth    = 32,
    parameter int unsigned WaitWidth    = 20,
    parameter int unsigned TimeoutWidth = 32,
    parameter int unsigned IdxWidth     = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       mode_all_i,
    input  logic [NumCh-1:0]           ch_en_i,
    input  logic [WaitWidth-1:0]       wait_cycles_i,
    input  logic [TimeoutWidth-1:0]    timeout_cycles_i,
    input  logic [NumCh-1:0]           eoc_valid_i,
    input  logic [NumCh*CodeWidth-1:0] eoc_code_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       fail_o,
    output logic                       timeout_o,
    output logic [CodeWidth-1:0]       exit_code_o,
    output logic [NumCh-1:0]           ch_done_o,
    output logic [IdxWidth-1:0]        first_ch_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StArmed = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [NumCh-1:0]     en_q, ch_done_q, ch_done_d, capture;
    logic                 mode_all_q;
    logic [WaitWidth-1:0] wait_q;
    logic [CodeWidth-1:0] code_q [NumCh];
    logic [CodeWidth-1:0] exit_code, capture_code;
    logic [IdxWidth-1:0]  first_idx, first_ch_q;
    logic                 fail_q;
    logic                 start_ok, complete, expire;

    assign start_ok  = start_i & ((state_q == StIdle) | (state_q == StDone));
    assign capture   = (state_q == StArmed) ? (eoc_valid_i & en_q & ~ch_done_q) : '0;
    assign ch_done_d = ch_done_q | capture;
    assign complete  = (state_q == StArmed) &
                       (mode_all_q ? (ch_done_d == en_q) : (ch_done_d != '0));

    // Descending scan so the lowest capturing index is the one left in first_idx.
    always_comb begin
        exit_code    = '0;
        capture_code = '0;
        first_idx    = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            exit_code = exit_code | code_q[i];
            if (capture[i]) begin
                capture_code = capture_code | eoc_code_i[i*CodeWidth +: CodeWidth];
                first_idx    = IdxWidth'(i);
            end
        end
    end

`ifdef CARFIELD_EOC_TIMEOUT_EN
    logic [TimeoutWidth-1:0] tmo_limit_q, tmo_cnt_q;
    logic                    timeout_q;

    assign expire = (state_q == StArmed) & (tmo_limit_q != '0) &
                    (tmo_cnt_q == tmo_limit_q - TimeoutWidth'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_limit_q <= '0;
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                tmo_limit_q <= timeout_cycles_i;
                timeout_q   <= 1'b0;
            end else if (expire & ~complete) begin
                timeout_q <= 1'b1;
            end
            if (state_q != StArmed) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_q <= tmo_cnt_q + TimeoutWidth'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^timeout_cycles_i;
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    if (ch_en_i == '0) begin
                        state_d = StDone;
                    end else if (wait_cycles_i == '0) begin
                        state_d = StArmed;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait:  if (wait_q == WaitWidth'(1)) state_d = StArmed;
            StArmed: if (complete | expire) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            en_q       <= '0;
            mode_all_q <= 1'b0;
            wait_q     <= '0;
            ch_done_q  <= '0;
            fail_q     <= 1'b0;
            first_ch_q <= '0;
            for (int i = 0; i < NumCh; i++) code_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                en_q       <= ch_en_i;
                mode_all_q <= mode_all_i;
                wait_q     <= wait_cycles_i;
                ch_done_q  <= '0;
                fail_q     <= (ch_en_i == '0);
                first_ch_q <= '0;
                for (int i = 0; i < NumCh; i++) code_q[i] <= '0;
            end else begin
                if ((state_q == StWait) && (wait_q != '0)) wait_q <= wait_q - WaitWidth'(1);
                ch_done_q <= ch_done_d;
                for (int i = 0; i < NumCh; i++) begin
                    if (capture[i]) code_q[i] <= eoc_code_i[i*CodeWidth +: CodeWidth];
                end
                if ((ch_done_q == '0) && (capture != '0)) first_ch_q <= first_idx;
                // Verdict uses post-capture codes; completion beats a coincident timeout.
                if ((state_q == StArmed) && (state_d == StDone)) begin
                    fail_q <= ((exit_code | capture_code) != '0) | (expire & ~complete);
                end
            end
        end
    end

    assign busy_o      = (state_q == StWait) | (state_q == StArmed);
    assign done_o      = (state_q == StDone);
    assign fail_o      = fail_q;
    assign exit_code_o = exit_code;
    assign ch_done_o   = ch_done_q;
    assign first_ch_o  = first_ch_q;

endmodule

// File: tb/tb_carfield_eoc_collector.sv
// Bench for carfield_eoc_collector: directed scenarios plus random transactions checked
// every cycle against a transaction-level outcome model.
module tb_carfield_eoc_collector;

    localparam int NumCh        = 4;
    localparam int CodeWidth    = 32;
    localparam int WaitWidth    = 20;
    localparam int TimeoutWidth = 32;
    localparam int IdxWidth     = 2;
    localparam int LMax         = 48;
    localparam int Inf          = 1 << 20;
`ifdef CARFIELD_EOC_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic                       mode_all = 1'b0;
    logic [NumCh-1:0]           ch_en = '0;
    logic [WaitWidth-1:0]       wait_cycles = '0;
    logic [TimeoutWidth-1:0]    timeout_cycles = '0;
    logic [NumCh-1:0]           eoc_valid = '0;
    logic [NumCh*CodeWidth-1:0] eoc_code = '0;
    logic                       busy, done, fail, timeout;
    logic [CodeWidth-1:0]       exit_code;
    logic [NumCh-1:0]           ch_done;
    logic [IdxWidth-1:0]        first_ch;

    int checks = 0;
    int failures = 0;

    logic [NumCh-1:0]     st_vld   [LMax];
    logic [CodeWidth-1:0] st_code  [LMax][NumCh];
    logic                 st_start [LMax];

    always #5 clk = ~clk;

    carfield_eoc_collector #(
        .NumCh(NumCh), .CodeWidth(CodeWidth), .WaitWidth(WaitWidth),
        .TimeoutWidth(TimeoutWidth), .IdxWidth(IdxWidth)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_all_i(mode_all),
        .ch_en_i(ch_en), .wait_cycles_i(wait_cycles), .timeout_cycles_i(timeout_cycles),
        .eoc_valid_i(eoc_valid), .eoc_code_i(eoc_code),
        .busy_o(busy), .done_o(done), .fail_o(fail), .timeout_o(timeout),
        .exit_code_o(exit_code), .ch_done_o(ch_done), .first_ch_o(first_ch)
    );

    task automatic chk(input string tag, input int cyc, input string what,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s cyc=%0d observed=%0h expected=%0h", tag, what, cyc, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk(tag, -1, "busy", 64'(busy), 64'd0);
        chk(tag, -1, "done", 64'(done), 64'd0);
        chk(tag, -1, "fail", 64'(fail), 64'd0);
        chk(tag, -1, "timeout", 64'(timeout), 64'd0);
        chk(tag, -1, "exit_code", 64'(exit_code), 64'd0);
        chk(tag, -1, "ch_done", 64'(ch_done), 64'd0);
        chk(tag, -1, "first_ch", 64'(first_ch), 64'd0);
    endtask

    task automatic clear_stim();
        for (int k = 0; k < LMax; k++) begin
            st_vld[k]   = '0;
            st_start[k] = 1'b0;
            for (int i = 0; i < NumCh; i++) st_code[k][i] = $urandom;
        end
    endtask

    task automatic put(input int k, input int ch, input logic [CodeWidth-1:0] code);
        st_vld[k][ch]  = 1'b1;
        st_code[k][ch] = code;
    endtask

    task automatic fill_random(input int len);
        clear_stim();
        for (int k = 1; k < len; k++) begin
            st_start[k] = ($urandom_range(7) == 0);
            for (int i = 0; i < NumCh; i++) begin
                if ($urandom_range(7) == 0)
                    put(k, i, ($urandom_range(1) == 0) ? '0 : CodeWidth'($urandom_range(255)));
            end
        end
    endtask

    // Outcome is derived from each channel's first eligible strobe cycle; cycle 0 carries start.
    task automatic run_txn(input string tag, input logic [NumCh-1:0] en, input bit mode,
                           input int w, input int tmo, input int len);
        int cap [NumCh];
        int first_arm, compl, tmo_at, last, lo;
        bit timed_out, fin;
        logic [NumCh-1:0]     exp_ch;
        logic [CodeWidth-1:0] exp_code;
        logic [IdxWidth-1:0]  exp_first;

        first_arm = w + 1;
        for (int i = 0; i < NumCh; i++) begin
            cap[i] = Inf;
            if (en[i]) begin
                for (int k = len - 1; k >= first_arm; k--) if (st_vld[k][i]) cap[i] = k;
            end
        end
        if (en == '0) begin
            last = 0;
            timed_out = 1'b0;
        end else begin
            compl = mode ? 0 : Inf;
            for (int i = 0; i < NumCh; i++) begin
                if (en[i]) compl = mode ? ((cap[i] > compl) ? cap[i] : compl)
                                        : ((cap[i] < compl) ? cap[i] : compl);
            end
            tmo_at    = (TmoEn && tmo != 0) ? first_arm + tmo - 1 : Inf;
            timed_out = (compl > tmo_at);
            last      = timed_out ? tmo_at : compl;
        end

        for (int k = 0; k < len; k++) begin
            start          = (k == 0) || (st_start[k] && k <= last);
            ch_en          = (k == 0) ? en : NumCh'($urandom);
            mode_all       = (k == 0) ? mode : 1'($urandom);
            wait_cycles    = (k == 0) ? WaitWidth'(w) : WaitWidth'($urandom_range(15));
            timeout_cycles = (k == 0) ? TimeoutWidth'(tmo) : TimeoutWidth'($urandom_range(30));
            eoc_valid      = st_vld[k];
            for (int i = 0; i < NumCh; i++) eoc_code[i*CodeWidth +: CodeWidth] = st_code[k][i];
            @(posedge clk);
            #1;
            fin       = (k >= last);
            exp_ch    = '0;
            exp_code  = '0;
            exp_first = '0;
            lo        = Inf;
            for (int i = 0; i < NumCh; i++) begin
                if (cap[i] <= k && cap[i] <= last) begin
                    exp_ch[i] = 1'b1;
                    exp_code  = exp_code | st_code[cap[i]][i];
                    if (cap[i] < lo) begin
                        lo = cap[i];
                        exp_first = IdxWidth'(i);
                    end
                end
            end
            chk(tag, k, "busy", 64'(busy), 64'(!fin));
            chk(tag, k, "done", 64'(done), 64'(fin));
            chk(tag, k, "fail", 64'(fail),
                64'(fin && (exp_code != '0 || timed_out || en == '0)));
            chk(tag, k, "timeout", 64'(timeout), 64'(fin && timed_out));
            chk(tag, k, "exit_code", 64'(exit_code), 64'(exp_code));
            chk(tag, k, "ch_done", 64'(ch_done), 64'(exp_ch));
            chk(tag, k, "first_ch", 64'(first_ch), 64'(exp_first));
        end
        start     = 1'b0;
        eoc_valid = '0;
        // A transaction still running at the end of its window is killed by an async reset.
        if (last >= len) begin
            rst_n = 1'b0;
            #1;
            check_zero({tag, "_rst"});
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        int w;
        int len;
        #12;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_zero("idle");

        clear_stim();
        put(1, 0, 32'h0);
        put(4, 2, 32'h0);
        put(2, 1, 32'h77);
        run_txn("all_0101", 4'b0101, 1'b1, 0, 0, 8);

        clear_stim();
        put(3, 1, 32'h9);
        put(7, 3, 32'h2A);
        put(7, 1, 32'h1);
        run_txn("any_wait5", 4'b1111, 1'b0, 5, 0, 12);

        clear_stim();
        run_txn("empty_mask", 4'b0000, 1'b1, 3, 0, 4);

        clear_stim();
        put(1, 0, 32'h0);
        run_txn("timeout", 4'b0011, 1'b1, 0, 8, 14);

        clear_stim();
        put(1, 0, 32'h0);
        put(8, 1, 32'h0);
        run_txn("tmo_tie", 4'b0011, 1'b1, 0, 8, 12);

        clear_stim();
        put(2, 0, 32'h5);
        put(4, 0, 32'h0);
        st_start[3] = 1'b1;
        st_start[6] = 1'b1;
        run_txn("first_kept", 4'b0011, 1'b1, 0, 0, 10);

        for (int t = 0; t < 30; t++) begin
            w   = $urandom_range(8);
            len = w + 31;
            fill_random(len);
            run_txn("rand", NumCh'($urandom), 1'($urandom), w, $urandom_range(20), len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carfield_eoc_collector.md
Name: carfield_eoc_collector

Overview:
- Synthesisable multi-channel end-of-computation collector.
- Gathers exit codes from NumCh compute domains (host, safety island, clusters) into one done/pass/fail verdict.
- Supports a programmable arm delay (e.g. HyperRAM warm-up) and a completion timeout.
- Sits on the always-on control bus; its outputs feed the EOC status register and the boot/preload sequencer.

Parameters:
- NumCh, 4, number of reporting channels (>=1)
- CodeWidth, 32, exit-code width per channel
- WaitWidth, 20, width of arm-delay counter
- TimeoutWidth, 32, width of timeout counter
- IdxWidth, (NumCh>1 ? $clog2(NumCh) : 1), channel index width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle start/restart pulse
- mode_all_i  in  1  1: all enabled channels must report; 0: any one suffices
- ch_en_i  in  NumCh  channel enable mask
- wait_cycles_i  in  WaitWidth  arm delay in cycles
- timeout_cycles_i  in  TimeoutWidth  ARMED-cycle limit; 0 = no timeout
- eoc_valid_i  in  NumCh  per-channel EOC strobe
- eoc_code_i  in  NumCh*CodeWidth  per-channel exit code, channel i at [i*CodeWidth +: CodeWidth]
- busy_o  out  1  in WAIT or ARMED
- done_o  out  1  verdict valid (state DONE)
- fail_o  out  1  nonzero aggregate code, timeout, or empty mask
- timeout_o  out  1  terminated by timeout
- exit_code_o  out  CodeWidth  bitwise OR of captured codes
- ch_done_o  out  NumCh  channels that have reported
- first_ch_o  out  IdxWidth  lowest-index channel in the first reporting cycle

Behaviour:
- Reset: state IDLE; all outputs and internal registers 0.
- FSM states: IDLE, WAIT, ARMED, DONE.
- start_i is honoured only in IDLE or DONE; it is ignored in WAIT and ARMED.
- On an honoured start_i:
  - latch ch_en_i, mode_all_i, timeout_cycles_i;
  - clear ch_done_o, exit_code_o, fail_o, timeout_o, first_ch_o and the captured codes;
  - load the wait counter with wait_cycles_i.
- Next state after start_i: ch_en_i==0 -> DONE with fail_o=1; wait_cycles_i==0 -> ARMED; otherwise -> WAIT.
- WAIT:
  - lasts exactly wait_cycles_i cycles; the counter decrements each cycle and WAIT->ARMED occurs when the counter is 1;
  - eoc_valid_i is ignored.
- ARMED capture:
  - each cycle, channel i captures when eoc_valid_i[i] & en[i] & ~ch_done[i]; it sets ch_done[i] and registers its code;
  - later strobes on a done channel are ignored (first code kept);
  - strobes on disabled channels are ignored.
- exit_code_o is the OR of all captured codes and updates the cycle after capture.
- first_ch_o is set once, on the first cycle with at least one capture. If several channels capture in that cycle, the lowest index wins.
- Completion, evaluated on post-capture state:
  - mode_all: ch_done == en;
  - mode_any: |ch_done;
  - on completion, the next state is DONE, so done_o rises the cycle after the completing strobe.
- Timeout counter:
  - cleared on entry to ARMED and incremented each ARMED cycle;
  - if timeout_cycles != 0 and the counter reaches timeout_cycles-1 without completion, go to DONE with timeout_o=1 and fail_o=1;
  - if completion and timeout fall in the same cycle, completion wins and timeout_o=0.
- DONE: all outputs hold. fail_o = (exit_code_o != 0) | timeout_o | empty mask.
- Width rules: the counters saturate and never wrap. The OR aggregate is exactly CodeWidth bits wide.
- Async reset mid-operation returns to IDLE immediately and clears everything.

Optional Feature:
- Macro: CARFIELD_EOC_TIMEOUT_EN.
- When defined: the timeout counter and timeout_o logic are present as described.
- When undefined:
  - the counter is not instantiated;
  - timeout_o is tied 0 and timeout_cycles_i is unused;
  - ARMED waits indefinitely for completion.

Test Plan:
- Reset, then idle for 10 cycles -> all outputs 0, busy_o=0.
- NumCh=4, en=4'b0101, mode_all=1, wait=0. Ch0 strobes code 0 at T, ch2 strobes 0 at T+3 -> done_o at T+4, fail_o=0, ch_done_o=4'b0101, first_ch_o=0.
- mode_all=0, en=4'b1111, wait=5. Ch1 strobes during WAIT (ignored). Ch3 (code 0x2A) and ch1 (code 0x1) strobe together in ARMED -> exit_code_o=0x2B, fail_o=1, first_ch_o=1.
- Timeout with macro on: en=4'b0011, mode_all=1, timeout=8, only ch0 reports -> done_o and timeout_o=1 after 8 ARMED cycles, ch_done_o=4'b0001. Repeat with ch1 strobing on the last ARMED cycle -> timeout_o=0, fail_o=0.
- Ch0 strobes 0x5 then 0x0 while mode_all still waits on ch1; start_i pulsed during ARMED -> first code 0x5 kept; start ignored.
- Restart from DONE with en=0 -> DONE next cycle with fail_o=1, exit_code_o=0. Assert rst_ni low mid-ARMED -> everything 0 immediately.
